// File: rtl/algofoogle_tracer_pkg.sv
// Shared definitions for the nibble-serial tracer host driver.
// Holds the transaction state encoding, Q6.10 width constants and
// small state-sequencing helpers used by algofoogle_tracer_driver.
package algofoogle_tracer_pkg;

  localparam int unsigned INT_BITS          = 6;
  localparam int unsigned FRAC_BITS         = 10;
  localparam int unsigned Q_BITS            = INT_BITS + FRAC_BITS;
  localparam int unsigned NIBBLES           = 4;
  localparam int unsigned NIBBLE_BITS       = Q_BITS / NIBBLES;
  localparam int unsigned TT_CYCLES_PER_TXN = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD0,
    ST_LOAD1,
    ST_LOAD2,
    ST_LOAD3,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } state_e;

  // Successor of each tracer-cycle state; IDLE/DONE are left by handshakes.
  function automatic state_e next_state(input state_e st);
    case (st)
      ST_SYNC:  return ST_LOAD0;
      ST_LOAD0: return ST_LOAD1;
      ST_LOAD1: return ST_LOAD2;
      ST_LOAD2: return ST_LOAD3;
      ST_LOAD3: return ST_RD_LO;
      ST_RD_LO: return ST_RD_HI;
      ST_RD_HI: return ST_DONE;
      default:  return st;
    endcase
  endfunction

  function automatic logic is_load(input state_e st);
    return (st == ST_LOAD0) || (st == ST_LOAD1) ||
           (st == ST_LOAD2) || (st == ST_LOAD3);
  endfunction

endpackage

// File: rtl/algofoogle_tt_phase_gen.sv
// Tracer clock phase generator.
// Produces tt_clk as HALF_PERIOD clk cycles low followed by HALF_PERIOD
// cycles high while enabled; held low at count 0 while disabled.
// Ports:
//   clk, reset_n : system clock, synchronous active-low reset
//   en           : run the tracer clock
//   tt_clk       : tracer clock
//   pre_rise     : last clk of the low phase (tt_out sample point)
//   cyc_end      : last clk of the high phase (tracer cycle boundary)
module algofoogle_tt_phase_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tt_clk,
  output logic pre_rise,
  output logic cyc_end
);

  localparam int unsigned   CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tt_clk   = phase_q;
  assign pre_rise = en && !phase_q && wrap;
  assign cyc_end  = en &&  phase_q && wrap;

endmodule

// File: rtl/algofoogle_tracer_driver.sv
// Host-side initiator for the nibble-serial reciprocal tracer port.
// Accepts a Q6.10 operand, resets the tracer step counter, shifts the
// operand out MSB-nibble first, reads back the result low byte then high
// byte, and offers the reassembled Q6.10 reciprocal.
// Ports:
//   clk, reset_n          : system clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake, in_data = Q6.10 operand
//   res_valid/res_ready   : result handshake, res_data = {hi_byte, lo_byte}
//   tt_clk/tt_reset       : generated tracer clock and active-high reset
//   tt_data               : nibble driven to the tracer
//   tt_out                : byte returned by the tracer
module algofoogle_tracer_driver
  import algofoogle_tracer_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Q_BITS-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [Q_BITS-1:0] res_data,
  output logic              tt_clk,
  output logic              tt_reset,
  output logic [3:0]        tt_data,
  input  logic [7:0]        tt_out
);

  state_e                 state_q, state_d;
  logic [Q_BITS-1:0]      shift_q, shift_d;
  logic [7:0]             lo_q, lo_d;
  logic [7:0]             hi_q, hi_d;
  logic [Q_BITS-1:0]      res_q, res_d;
  logic                   in_ready_q;
  logic                   res_valid_q;
  logic                   tt_reset_q;
  logic [NIBBLE_BITS-1:0] tt_data_q, tt_data_d;

  logic phase_en;
  logic pre_rise;
  logic cyc_end;

  assign phase_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

  algofoogle_tt_phase_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (phase_en),
    .tt_clk  (tt_clk),
    .pre_rise(pre_rise),
    .cyc_end (cyc_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    res_d     = res_q;
    tt_data_d = tt_data_q;

    case (state_q)
      ST_IDLE: begin
        // Gate on the registered ready so nothing is taken in the cycle
        // right after reset release, before in_ready has been raised.
        if (in_valid && in_ready_q) begin
          state_d = ST_SYNC;
          shift_d = in_data;
        end
      end
      ST_RD_LO: begin
        if (pre_rise) lo_d = tt_out;
        if (cyc_end) state_d = next_state(state_q);
      end
      ST_RD_HI: begin
        if (pre_rise) hi_d = tt_out;
        if (cyc_end) begin
          state_d = ST_DONE;
          res_d   = {hi_q, lo_q};
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: begin
        if (cyc_end) state_d = next_state(state_q);
      end
    endcase

    // Pin outputs are registered from the next state so they change on the
    // same edge that opens a low phase and stay put until the next one.
    if (state_d != state_q) begin
      if (is_load(state_d)) begin
        tt_data_d = shift_q[Q_BITS-1 -: NIBBLE_BITS];
        shift_d   = shift_q << NIBBLE_BITS;
      end else begin
        tt_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      tt_reset_q  <= 1'b1;
      tt_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      res_q       <= res_d;
      in_ready_q  <= (state_d == ST_IDLE);
      res_valid_q <= (state_d == ST_DONE);
      tt_reset_q  <= (state_d == ST_SYNC);
      tt_data_q   <= tt_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign tt_reset  = tt_reset_q;
  assign tt_data   = tt_data_q;

endmodule

// File: tb/tb_algofoogle_tracer_driver.sv
// Bench for algofoogle_tracer_driver: instance A at HALF_PERIOD=2,
// instance B at HALF_PERIOD=1, each talking to a behavioural tracer.
module tb_algofoogle_tracer_driver;
  import algofoogle_tracer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        in_valid_a, in_ready_a, res_valid_a, res_ready_a, tt_clk_a, tt_reset_a;
  logic [15:0] in_data_a, res_data_a;
  logic [3:0]  tt_data_a;
  logic [7:0]  tt_out_a;

  logic        in_valid_b, in_ready_b, res_valid_b, res_ready_b, tt_clk_b, tt_reset_b;
  logic [15:0] in_data_b, res_data_b;
  logic [3:0]  tt_data_b;
  logic [7:0]  tt_out_b;

  algofoogle_tracer_driver #(.HALF_PERIOD(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a),
    .tt_clk(tt_clk_a), .tt_reset(tt_reset_a), .tt_data(tt_data_a), .tt_out(tt_out_a)
  );

  algofoogle_tracer_driver #(.HALF_PERIOD(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
    .tt_clk(tt_clk_b), .tt_reset(tt_reset_b), .tt_data(tt_data_b), .tt_out(tt_out_b)
  );

  int checks = 0;
  int errors = 0;

  // Q6.10 reciprocal: 2^20 / x, saturating; x=0 saturates as well.
  function automatic logic [15:0] ref_recip(input logic [15:0] x);
    longint unsigned q;
    if (x == 16'h0) return 16'hFFFF;
    q = (64'd1 << 20) / longint'(x);
    if (q > 64'hFFFF) return 16'hFFFF;
    return q[15:0];
  endfunction

  function automatic logic [7:0] trc_byte(input int step, input logic [15:0] op, input bit frc);
    logic [15:0] r;
    r = frc ? 16'hA53C : ref_recip(op);
    if (step == 4) return r[7:0];
    if (step == 5) return r[15:8];
    return 8'h00;
  endfunction

  // Behavioural tracers: step counter, nibble shift-in, step 4 = lo, step 5 = hi.
  int          step_a = 0, rises_a = 0;
  logic [15:0] op_a = '0;
  bit          force_a = 1'b0;
  logic [3:0]  nib_a[8];
  logic        rst_a[8];

  always @(posedge tt_clk_a) begin
    if (rises_a < 8) begin
      nib_a[rises_a] = tt_data_a;
      rst_a[rises_a] = tt_reset_a;
    end
    rises_a++;
    if (tt_reset_a) step_a = 0;
    else begin
      if (step_a < 4) op_a = {op_a[11:0], tt_data_a};
      step_a = (step_a == 5) ? 0 : step_a + 1;
    end
  end
  assign tt_out_a = trc_byte(step_a, op_a, force_a);

  int          step_b = 0, rises_b = 0;
  logic [15:0] op_b = '0;

  always @(posedge tt_clk_b) begin
    rises_b++;
    if (tt_reset_b) step_b = 0;
    else begin
      if (step_b < 4) op_b = {op_b[11:0], tt_data_b};
      step_b = (step_b == 5) ? 0 : step_b + 1;
    end
  end
  assign tt_out_b = trc_byte(step_b, op_b, 1'b0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance A; returns result and accept-to-valid latency.
  task automatic txn_a(input logic [15:0] op, input int hold, output logic [15:0] got, output int lat);
    int n;
    rises_a    = 0;
    in_valid_a = 1'b1;
    in_data_a  = op;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    in_valid_a = 1'b0;
    in_data_a  = 16'($urandom);
    checks++;
    if (in_ready_a !== 1'b0) begin
      errors++; $display("FAIL busy_ready: in_ready=%b want 0", in_ready_a);
    end
    lat = 0;
    while (res_valid_a !== 1'b1 && lat < 200) begin tick(); lat++; end
    got = res_data_a;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (res_valid_a !== 1'b1 || res_data_a !== got || in_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: valid=%b data=%h ready=%b want 1 %h 0", res_valid_a, res_data_a, in_ready_a, got);
      end
    end
    res_ready_a = 1'b1;
    tick();
    res_ready_a = 1'b0;
    checks++;
    if (res_valid_a !== 1'b0 || in_ready_a !== 1'b1 || res_data_a !== got) begin
      errors++;
      $display("FAIL done_exit: valid=%b ready=%b data=%h want 0 1 %h", res_valid_a, in_ready_a, res_data_a, got);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (tt_reset_a !== 1'b1 || tt_clk_a !== 1'b0 || in_ready_a !== 1'b0 || res_valid_a !== 1'b0 ||
        res_data_a !== 16'h0 || tt_data_a !== 4'h0 || tt_reset_b !== 1'b1 || in_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tt_reset=%b tt_clk=%b ready=%b valid=%b data=%h nib=%h",
               tt_reset_a, tt_clk_a, in_ready_a, res_valid_a, res_data_a, tt_data_a);
    end
    reset_n = 1'b1;
    rises_a = 0;
    rises_b = 0;
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || tt_reset_a !== 1'b0 || in_ready_b !== 1'b1 || tt_reset_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b tt_reset=%b want 1 0", in_ready_a, tt_reset_a);
    end
    repeat (10) tick();
    checks++;
    if (rises_a != 0 || rises_b != 0 || tt_clk_a !== 1'b0) begin
      errors++; $display("FAIL idle_rises: a=%0d b=%0d want 0", rises_a, rises_b);
    end
  endtask

  task automatic test_nibble_order();
    logic [15:0] got;
    int lat;
    txn_a(16'h1234, 0, got, lat);
    checks++;
    if (rises_a != TT_CYCLES_PER_TXN) begin
      errors++; $display("FAIL rise_count: got %0d want %0d", rises_a, TT_CYCLES_PER_TXN);
    end
    checks++;
    if (rst_a[0] !== 1'b1 || rst_a[1] !== 1'b0 || rst_a[2] !== 1'b0 || rst_a[3] !== 1'b0 ||
        rst_a[4] !== 1'b0 || rst_a[5] !== 1'b0 || rst_a[6] !== 1'b0) begin
      errors++;
      $display("FAIL sync_reset: rst@rises=%b%b%b%b%b%b%b want 1000000",
               rst_a[0], rst_a[1], rst_a[2], rst_a[3], rst_a[4], rst_a[5], rst_a[6]);
    end
    checks++;
    if ({nib_a[1], nib_a[2], nib_a[3], nib_a[4]} !== 16'h1234) begin
      errors++;
      $display("FAIL nibble_order: got %h%h%h%h want 1234", nib_a[1], nib_a[2], nib_a[3], nib_a[4]);
    end
    checks++;
    if (got !== ref_recip(16'h1234)) begin
      errors++; $display("FAIL recip_1234: got %h want %h", got, ref_recip(16'h1234));
    end
  endtask

  task automatic test_recip_one();
    logic [15:0] got;
    int lat;
    txn_a(16'h0400, 0, got, lat);
    checks++;
    if (got !== 16'h0400 || lat != 28) begin
      errors++; $display("FAIL recip_1p0: got %h lat %0d want 0400 lat 28", got, lat);
    end
    txn_a(16'h0800, 0, got, lat);
    checks++;
    if (got !== 16'h0200 || lat != 28) begin
      errors++; $display("FAIL recip_2p0: got %h lat %0d want 0200 lat 28", got, lat);
    end
  endtask

  task automatic test_byte_assembly();
    logic [15:0] got;
    int lat;
    force_a = 1'b1;
    txn_a(16'($urandom), 10, got, lat);
    force_a = 1'b0;
    checks++;
    if (got !== 16'hA53C) begin
      errors++; $display("FAIL byte_assembly: got %h want a53c", got);
    end
    // Result register keeps its value after the handshake.
    checks++;
    if (res_data_a !== 16'hA53C) begin
      errors++; $display("FAIL res_retained: got %h want a53c", res_data_a);
    end
  endtask

  task automatic test_random();
    logic [15:0] op, got, exp_nibs;
    int lat;
    for (int k = 0; k < 8; k++) begin
      op = 16'($urandom_range(1, 16'hFFFF));
      txn_a(op, $urandom_range(0, 3), got, lat);
      exp_nibs = op;
      checks++;
      if (got !== ref_recip(op) || lat != 28 || rises_a != TT_CYCLES_PER_TXN ||
          {nib_a[1], nib_a[2], nib_a[3], nib_a[4]} !== exp_nibs) begin
        errors++;
        $display("FAIL random_txn: op=%h got=%h lat=%0d rises=%0d want %h lat 28 rises 7",
                 op, got, lat, rises_a, ref_recip(op));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] got;
    int lat, n;
    bit seen;
    rises_a    = 0;
    in_valid_a = 1'b1;
    in_data_a  = 16'h1234;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    in_valid_a = 1'b0;
    // LOAD2 spans cycles 12..15 after acceptance at HALF_PERIOD=2.
    repeat (13) tick();
    checks++;
    if (tt_data_a !== 4'h3 || rises_a != 3) begin
      errors++; $display("FAIL load2_point: nib=%h rises=%0d want 3 3", tt_data_a, rises_a);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (tt_reset_a !== 1'b1 || tt_clk_a !== 1'b0 || res_valid_a !== 1'b0 ||
        in_ready_a !== 1'b0 || rises_a != 3) begin
      errors++;
      $display("FAIL mid_reset: tt_reset=%b tt_clk=%b valid=%b ready=%b rises=%0d want 1 0 0 0 3",
               tt_reset_a, tt_clk_a, res_valid_a, in_ready_a, rises_a);
    end
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (res_valid_a === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || rises_a != 3) begin
      errors++; $display("FAIL aborted_result: valid_seen=%b rises=%0d want 0 3", seen, rises_a);
    end
    txn_a(16'h0400, 0, got, lat);
    checks++;
    if (got !== 16'h0400 || lat != 28) begin
      errors++; $display("FAIL after_reset_txn: got %h lat %0d want 0400 28", got, lat);
    end
  endtask

  task automatic test_back_to_back();
    int          n, acc2;
    bit          prev_rdy;
    int          v_t[$];
    logic [15:0] v_d[$];
    rises_b    = 0;
    in_valid_b = 1'b1;
    in_data_b  = 16'h0400;
    n = 0;
    while (in_ready_b !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    in_data_b = 16'h0800;
    acc2      = -1;
    prev_rdy  = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (res_valid_b === 1'b1) begin
        v_t.push_back(t);
        v_d.push_back(res_data_b);
      end
      if (acc2 < 0 && prev_rdy && in_valid_b) begin
        acc2       = t;
        in_valid_b = 1'b0;
      end
      prev_rdy = (in_ready_b === 1'b1);
    end
    checks++;
    if (v_t.size() != 2 || rises_b != 2 * TT_CYCLES_PER_TXN) begin
      errors++; $display("FAIL b2b_count: results=%0d rises=%0d want 2 14", v_t.size(), rises_b);
    end else begin
      checks++;
      if (v_t[0] != 14 || v_d[0] !== ref_recip(16'h0400)) begin
        errors++; $display("FAIL b2b_first: t=%0d data=%h want 14 %h", v_t[0], v_d[0], ref_recip(16'h0400));
      end
      checks++;
      if (acc2 - v_t[0] != 2 || v_t[1] - acc2 != 14 || v_d[1] !== ref_recip(16'h0800)) begin
        errors++;
        $display("FAIL b2b_second: accept=%0d valid=%0d data=%h want %0d %0d %h",
                 acc2, v_t[1], v_d[1], v_t[0] + 2, v_t[0] + 16, ref_recip(16'h0800));
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid_a  = 1'b0;
    in_data_a   = '0;
    res_ready_a = 1'b0;
    in_valid_b  = 1'b0;
    in_data_b   = '0;
    res_ready_b = 1'b1;
    test_reset();
    test_nibble_order();
    test_recip_one();
    test_byte_assembly();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
